// File: rtl/slot_gpio_pkg.sv
// ============================================================================
// Module      : slot_gpio_pkg
// Description : Register map and shared types for the slot GPIO/interrupt block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slot_gpio_pkg;

    localparam int c_default_data_w = 16;

    typedef logic [2:0] reg_offset_t;

    localparam reg_offset_t c_off_out        = 3'd0;
    localparam reg_offset_t c_off_in         = 3'd1;
    localparam reg_offset_t c_off_dir        = 3'd2;
    localparam reg_offset_t c_off_int_status = 3'd3;
    localparam reg_offset_t c_off_int_mask   = 3'd4;
    localparam reg_offset_t c_off_int_clear  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/slot_gpio_sync.sv
// ============================================================================
// Module      : slot_gpio_sync
// Description : Per-bit pad synchronizer; SLOT_GPIO_DEGLITCH_EN adds a
//               3-equal-sample deglitch filter behind it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_gpio_sync
    import slot_gpio_pkg::*;
#(
    parameter int DATA_W      = c_default_data_w,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] pad_i,
    output logic [DATA_W-1:0] sync_val
);

    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [c_stages-1:0][DATA_W-1:0] r_stage;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= pad_i;
            for (int i = 1; i < c_stages; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

`ifdef SLOT_GPIO_DEGLITCH_EN
    logic [DATA_W-1:0] r_hist0;
    logic [DATA_W-1:0] r_hist1;
    logic [DATA_W-1:0] r_filt;
    logic [DATA_W-1:0] w_stable;
    logic [DATA_W-1:0] w_filt;

    // The live synchronizer output counts as the third sample, so the filter
    // adds only two cycles over the bare synchronizer.
    always_comb begin
        w_stable = ~(r_stage[c_stages-1] ^ r_hist0) & ~(r_hist0 ^ r_hist1);
        w_filt   = (w_stable & r_stage[c_stages-1]) | (~w_stable & r_filt);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_filt  <= '0;
        end else begin
            r_hist0 <= r_stage[c_stages-1];
            r_hist1 <= r_hist0;
            r_filt  <= w_filt;
        end
    end

    assign sync_val = w_filt;
`else
    assign sync_val = r_stage[c_stages-1];
`endif

endmodule

`default_nettype wire

// File: rtl/slot_gpio_irq.sv
// ============================================================================
// Module      : slot_gpio_irq
// Description : Slot GPIO register block with sticky rising-edge interrupts.
//               Optional input deglitch filter: SLOT_GPIO_DEGLITCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slot_gpio_irq
    import slot_gpio_pkg::*;
#(
    parameter int DATA_W      = c_default_data_w,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [2:0]        reg_addr,
    input  logic              reg_we,
    input  logic [DATA_W-1:0] reg_wdata,
    input  logic              reg_re,
    output logic [DATA_W-1:0] reg_rdata,
    output logic              reg_rvalid,
    input  logic [DATA_W-1:0] pad_i,
    output logic [DATA_W-1:0] pad_o,
    output logic [DATA_W-1:0] pad_oe,
    output logic              irq
);

    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`ifdef SLOT_GPIO_DEGLITCH_EN
    localparam int c_filter_lat = 2;
`else
    localparam int c_filter_lat = 0;
`endif
    localparam int c_arm_cycles = c_stages + 1 + c_filter_lat;
    localparam int c_arm_w      = $clog2(c_arm_cycles + 1);

    logic [DATA_W-1:0]  r_out;
    logic [DATA_W-1:0]  r_dir;
    logic [DATA_W-1:0]  r_mask;
    logic [DATA_W-1:0]  r_status;
    logic [DATA_W-1:0]  r_prev;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_rvalid;
    logic               r_irq;
    logic [c_arm_w-1:0] r_arm_cnt;

    logic [DATA_W-1:0]  w_sync;
    logic [DATA_W-1:0]  w_rise;
    logic [DATA_W-1:0]  w_clear;
    logic [DATA_W-1:0]  w_rd_mux;
    logic               w_armed;

    slot_gpio_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (c_stages)
    ) u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .pad_i    (pad_i),
        .sync_val (w_sync)
    );

    // Edges stay masked until the pipeline has flushed the reset zeros, so a
    // pin held high across reset never looks like a rising edge.
    always_comb begin
        w_armed = (r_arm_cnt == c_arm_w'(c_arm_cycles));
        w_rise  = w_armed ? (w_sync & ~r_prev & ~r_dir) : '0;
        w_clear = (reg_we && (reg_addr == c_off_int_clear)) ? reg_wdata : '0;
        w_rd_mux = '0;
        case (reg_addr)
            c_off_out:        w_rd_mux = r_out;
            c_off_in:         w_rd_mux = w_sync;
            c_off_dir:        w_rd_mux = r_dir;
            c_off_int_status: w_rd_mux = r_status;
            c_off_int_mask:   w_rd_mux = r_mask;
            default:          w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_mask    <= '0;
            r_status  <= '0;
            r_prev    <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
            r_irq     <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
            end
            r_prev <= w_sync;
            if (reg_we) begin
                case (reg_addr)
                    c_off_out:      r_out  <= reg_wdata;
                    c_off_dir:      r_dir  <= reg_wdata;
                    c_off_int_mask: r_mask <= reg_wdata;
                    default:        ;
                endcase
            end
            // A new edge overrides a coincident clear of the same bit.
            r_status <= (r_status & ~w_clear) | w_rise;
            r_irq    <= |(r_status & r_mask);
            r_rvalid <= reg_re;
            r_rdata  <= reg_re ? w_rd_mux : '0;
        end
    end

    assign reg_rdata  = r_rdata;
    assign reg_rvalid = r_rvalid;
    assign pad_o      = r_out;
    assign pad_oe     = r_dir;
    assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_slot_gpio_irq.sv
// ============================================================================
// Module      : tb_slot_gpio_irq
// Description : Directed self-checking bench for slot_gpio_irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slot_gpio_irq;

    localparam int DW = 16;
    localparam int SS = 2;
`ifdef SLOT_GPIO_DEGLITCH_EN
    localparam int FILT = 2;
`else
    localparam int FILT = 0;
`endif

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic [2:0]    reg_addr;
    logic          reg_we;
    logic [DW-1:0] reg_wdata;
    logic          reg_re;
    logic [DW-1:0] reg_rdata;
    logic          reg_rvalid;
    logic [DW-1:0] pad_i;
    logic [DW-1:0] pad_o;
    logic [DW-1:0] pad_oe;
    logic          irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] rd;

    slot_gpio_irq #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .reg_addr   (reg_addr),
        .reg_we     (reg_we),
        .reg_wdata  (reg_wdata),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .pad_i      (pad_i),
        .pad_o      (pad_o),
        .pad_oe     (pad_oe),
        .irq        (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [DW-1:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        tick(1);
        reg_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [DW-1:0] d);
        reg_addr = a;
        reg_re   = 1'b1;
        tick(1);
        reg_re   = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        pad_i   = 16'hFFFF;
        tick(3);
        n_cmp++;
        if (pad_o !== 16'h0 || pad_oe !== 16'h0) begin
            n_err++;
            $display("FAIL rst_pads: pad_o=%h pad_oe=%h expected 0000 0000", pad_o, pad_oe);
        end
        n_cmp++;
        if (irq !== 1'b0 || reg_rvalid !== 1'b0 || reg_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL rst_outs: irq=%b rvalid=%b rdata=%h expected 0 0 0000", irq, reg_rvalid, reg_rdata);
        end
        sys_rst = 1'b0;
        tick(SS + FILT + 6);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL rst_held_high_status: got %h expected 0000", rd);
        end
        reg_read(3'd1, rd);
        n_cmp++;
        if (rd !== 16'hFFFF) begin
            n_err++;
            $display("FAIL rst_in_high: got %h expected ffff", rd);
        end
        reg_read(3'd4, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL rst_mask: got %h expected 0000", rd);
        end
        pad_i = 16'h0;
        tick(SS + FILT + 3);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL falling_no_status: got %h expected 0000", rd);
        end
    endtask

    task automatic test_out_dir;
        reg_write(3'd2, 16'hFFFF);
        reg_write(3'd0, 16'h5555);
        n_cmp++;
        if (pad_o !== 16'h5555 || pad_oe !== 16'hFFFF) begin
            n_err++;
            $display("FAIL out_dir_pads: pad_o=%h pad_oe=%h expected 5555 ffff", pad_o, pad_oe);
        end
        reg_read(3'd0, rd);
        n_cmp++;
        if (reg_rvalid !== 1'b1 || rd !== 16'h5555) begin
            n_err++;
            $display("FAIL read_out: rvalid=%b rdata=%h expected 1 5555", reg_rvalid, rd);
        end
        tick(1);
        n_cmp++;
        if (reg_rvalid !== 1'b0 || reg_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL idle_rdata: rvalid=%b rdata=%h expected 0 0000", reg_rvalid, reg_rdata);
        end
        reg_write(3'd1, 16'h1234);
        reg_write(3'd6, 16'h0F0F);
        reg_write(3'd7, 16'h0000);
        reg_read(3'd0, rd);
        n_cmp++;
        if (rd !== 16'h5555) begin
            n_err++;
            $display("FAIL ignored_wr_out: got %h expected 5555", rd);
        end
        reg_read(3'd2, rd);
        n_cmp++;
        if (rd !== 16'hFFFF) begin
            n_err++;
            $display("FAIL read_dir: got %h expected ffff", rd);
        end
        reg_read(3'd5, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL read_clear: got %h expected 0000", rd);
        end
        reg_read(3'd6, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL read_off6: got %h expected 0000", rd);
        end
    endtask

    task automatic test_rw_same;
        reg_addr  = 3'd0;
        reg_wdata = 16'h1234;
        reg_we    = 1'b1;
        reg_re    = 1'b1;
        tick(1);
        reg_we = 1'b0;
        reg_re = 1'b0;
        n_cmp++;
        if (reg_rdata !== 16'h5555 || pad_o !== 16'h1234) begin
            n_err++;
            $display("FAIL rw_same: rdata=%h pad_o=%h expected 5555 1234", reg_rdata, pad_o);
        end
        reg_read(3'd0, rd);
        n_cmp++;
        if (rd !== 16'h1234) begin
            n_err++;
            $display("FAIL rw_after: got %h expected 1234", rd);
        end
    endtask

    task automatic test_in;
        reg_write(3'd2, 16'h0);
        tick(4);
        pad_i = 16'hAAAA;
        tick(SS - 1 + FILT);
        reg_read(3'd1, rd);
        n_cmp++;
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL in_too_early: got %h expected 0000", rd);
        end
        reg_read(3'd1, rd);
        n_cmp++;
        if (rd !== 16'hAAAA) begin
            n_err++;
            $display("FAIL in_latency: got %h expected aaaa", rd);
        end
        tick(2);
        reg_write(3'd3, 16'h0);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'hAAAA) begin
            n_err++;
            $display("FAIL in_edges_status: got %h expected aaaa", rd);
        end
    endtask

    task automatic test_irq;
        reg_write(3'd4, 16'hFFFF);
        pad_i = 16'h0;
        tick(SS + FILT + 3);
        reg_write(3'd5, 16'hFFFF);
        tick(2);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL irq_after_clear: got %b expected 0", irq);
        end
        pad_i = 16'h0001;
        tick(SS + FILT);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL edge_too_early: status=%h irq=%b expected 0000 0", rd, irq);
        end
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0001 || irq !== 1'b1) begin
            n_err++;
            $display("FAIL edge_latency: status=%h irq=%b expected 0001 1", rd, irq);
        end
        reg_write(3'd5, 16'h0001);
        tick(1);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL w1c_clear: status=%h irq=%b expected 0000 0", rd, irq);
        end
        reg_write(3'd4, 16'h0);
        pad_i = 16'h0003;
        tick(SS + FILT + 3);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0002 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL masked_sticky: status=%h irq=%b expected 0002 0", rd, irq);
        end
        reg_write(3'd4, 16'h0002);
        tick(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL unmask_irq: got %b expected 1", irq);
        end
    endtask

    task automatic test_dir_no_clear;
        reg_write(3'd2, 16'h0002);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0002) begin
            n_err++;
            $display("FAIL dir_keeps_status: got %h expected 0002", rd);
        end
        reg_write(3'd5, 16'hFFFF);
        pad_i = 16'h0001;
        tick(SS + FILT + 3);
        pad_i = 16'h0003;
        tick(SS + FILT + 3);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL output_pin_no_edge: status=%h irq=%b expected 0000 0", rd, irq);
        end
        reg_write(3'd2, 16'h0);
    endtask

    task automatic test_same_cycle;
        pad_i = 16'h0;
        tick(SS + FILT + 3);
        reg_write(3'd5, 16'hFFFF);
        pad_i = 16'h0001;
        tick(SS + FILT);
        reg_write(3'd5, 16'h0001);
        reg_read(3'd3, rd);
        n_cmp++;
        if (rd !== 16'h0001) begin
            n_err++;
            $display("FAIL set_beats_clear: got %h expected 0001", rd);
        end
    endtask

    task automatic test_pulse;
        reg_write(3'd5, 16'hFFFF);
        pad_i = 16'h0005;
        tick(1);
        pad_i = 16'h0001;
        tick(SS + FILT + 3);
        reg_read(3'd1, rd);
        n_cmp++;
        if (rd !== 16'h0001) begin
            n_err++;
            $display("FAIL pulse_in: got %h expected 0001", rd);
        end
        reg_read(3'd3, rd);
        n_cmp++;
`ifdef SLOT_GPIO_DEGLITCH_EN
        if (rd !== 16'h0) begin
            n_err++;
            $display("FAIL pulse_filtered: got %h expected 0000", rd);
        end
`else
        if (rd !== 16'h0004) begin
            n_err++;
            $display("FAIL pulse_captured: got %h expected 0004", rd);
        end
`endif
    endtask

    task automatic test_reset_abort;
        reg_addr = 3'd0;
        reg_re   = 1'b1;
        sys_rst  = 1'b1;
        tick(1);
        reg_re = 1'b0;
        n_cmp++;
        if (reg_rvalid !== 1'b0 || reg_rdata !== 16'h0 || pad_o !== 16'h0) begin
            n_err++;
            $display("FAIL rst_abort: rvalid=%b rdata=%h pad_o=%h expected 0 0000 0000",
                     reg_rvalid, reg_rdata, pad_o);
        end
        sys_rst = 1'b0;
        tick(2);
    endtask

    initial begin
        sys_rst   = 1'b1;
        reg_addr  = 3'd0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        reg_re    = 1'b0;
        pad_i     = '0;
        test_reset();
        test_out_dir();
        test_rw_same();
        test_in();
        test_irq();
        test_dir_no_clear();
        test_same_cycle();
        test_pulse();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
